// File: rtl/fas_pkg.sv
// Shared definitions for the FAS spectral peak detector: bin geometry, FSM
// state encoding and the helper that splits a packed bin into re/im.
package fas_pkg;

   localparam int N_BINS = 16;
   localparam int BIN_W  = 32;
   localparam int COMP_W = 16;
   localparam int MAG_W  = 32;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SCAN   = 2'd1,
      REPORT = 2'd2
   } state_e;

   typedef struct packed {
      logic signed [COMP_W-1:0] re;
      logic signed [COMP_W-1:0] im;
   } bin_t;

   function automatic bin_t unpack_bin(input logic [BIN_W-1:0] b);
      bin_t r;
      r.re = b[BIN_W-1:COMP_W];
      r.im = b[COMP_W-1:0];
      return r;
   endfunction

endpackage

// File: rtl/fas_mag2.sv
// Combinational squared magnitude of one complex bin: re^2 + im^2, returned
// unsigned. (-32768)^2 + (-32768)^2 = 2^31 still fits, so no saturation.
module fas_mag2 #(
   parameter int W = 16
) (
   input  logic signed [W-1:0]   re_i,
   input  logic signed [W-1:0]   im_i,
   output logic        [2*W-1:0] mag2_o
);

   logic signed [2*W-1:0] re_x;
   logic signed [2*W-1:0] im_x;
   logic signed [2*W-1:0] re_sq;
   logic signed [2*W-1:0] im_sq;

   // Sign-extend first so each product is formed at full result width.
   assign re_x   = (2*W)'(re_i);
   assign im_x   = (2*W)'(im_i);
   assign re_sq  = re_x * re_x;
   assign im_sq  = im_x * im_x;
   assign mag2_o = $unsigned(re_sq) + $unsigned(im_sq);

endmodule

// File: rtl/fas_peak_detect.sv
// Peak detector behind the FFT: captures a 16-bin frame, scans two bins per
// cycle for the largest squared magnitude and reports its index with done.
module fas_peak_detect
   import fas_pkg::*;
#(
   parameter int W = 16
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           fft_valid,
   input  logic [2*W-1:0] fft_d0,
   input  logic [2*W-1:0] fft_d1,
   input  logic [2*W-1:0] fft_d2,
   input  logic [2*W-1:0] fft_d3,
   input  logic [2*W-1:0] fft_d4,
   input  logic [2*W-1:0] fft_d5,
   input  logic [2*W-1:0] fft_d6,
   input  logic [2*W-1:0] fft_d7,
   input  logic [2*W-1:0] fft_d8,
   input  logic [2*W-1:0] fft_d9,
   input  logic [2*W-1:0] fft_d10,
   input  logic [2*W-1:0] fft_d11,
   input  logic [2*W-1:0] fft_d12,
   input  logic [2*W-1:0] fft_d13,
   input  logic [2*W-1:0] fft_d14,
   input  logic [2*W-1:0] fft_d15,
   output logic           done,
   output logic [3:0]     freq,
   output logic           busy,
   output logic           overrun
);

   logic [BIN_W-1:0] frame_in [N_BINS];
   logic [BIN_W-1:0] cap_q    [N_BINS];
   logic [BIN_W-1:0] work_q   [N_BINS];

   state_e           state_q, state_d;
   logic             pending_q, pending_d;
   logic [2:0]       k_q, k_d;
   logic [MAG_W-1:0] max_q, max_d;
   logic [3:0]       idx_q, idx_d;
   logic [3:0]       freq_q, freq_d;
   logic             done_q, done_d;
   logic             overrun_q, overrun_d;
   logic             load_work;

   logic [MAG_W-1:0] mag_even;
   logic [MAG_W-1:0] mag_odd;
   logic [MAG_W-1:0] max_mid;
   logic [3:0]       idx_mid;
   bin_t             bin_even;
   bin_t             bin_odd;

   assign frame_in[0]  = fft_d0;
   assign frame_in[1]  = fft_d1;
   assign frame_in[2]  = fft_d2;
   assign frame_in[3]  = fft_d3;
   assign frame_in[4]  = fft_d4;
   assign frame_in[5]  = fft_d5;
   assign frame_in[6]  = fft_d6;
   assign frame_in[7]  = fft_d7;
   assign frame_in[8]  = fft_d8;
   assign frame_in[9]  = fft_d9;
   assign frame_in[10] = fft_d10;
   assign frame_in[11] = fft_d11;
   assign frame_in[12] = fft_d12;
   assign frame_in[13] = fft_d13;
   assign frame_in[14] = fft_d14;
   assign frame_in[15] = fft_d15;

   assign bin_even = unpack_bin(work_q[{k_q, 1'b0}]);
   assign bin_odd  = unpack_bin(work_q[{k_q, 1'b1}]);

   fas_mag2 #(.W(COMP_W)) u_mag_even (
      .re_i   (bin_even.re),
      .im_i   (bin_even.im),
      .mag2_o (mag_even)
   );

   fas_mag2 #(.W(COMP_W)) u_mag_odd (
      .re_i   (bin_odd.re),
      .im_i   (bin_odd.im),
      .mag2_o (mag_odd)
   );

   // Strict '>' keeps the earlier bin on ties; the even bin is tried first.
   always_comb begin
      max_mid = max_q;
      idx_mid = idx_q;
      if (mag_even > max_q) begin
         max_mid = mag_even;
         idx_mid = {k_q, 1'b0};
      end
   end

   // NOTE: every output of this block gets a default first, so no path leaves a
   // signal unassigned and no latch is inferred.
   always_comb begin
      state_d   = state_q;
      k_d       = k_q;
      max_d     = max_q;
      idx_d     = idx_q;
      freq_d    = freq_q;
      done_d    = 1'b0;
      load_work = 1'b0;
      case (state_q)
         IDLE: begin
            if (pending_q) begin
               load_work = 1'b1;
               max_d     = '0;
               idx_d     = '0;
               k_d       = '0;
               state_d   = SCAN;
            end
         end
         SCAN: begin
            max_d = max_mid;
            idx_d = idx_mid;
            if (mag_odd > max_mid) begin
               max_d = mag_odd;
               idx_d = {k_q, 1'b1};
            end
            k_d = k_q + 3'd1;
            if (k_q == 3'd7) state_d = REPORT;
         end
         REPORT: begin
            freq_d  = idx_q;
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // A new frame landing on the same edge the old one is taken is not a loss.
   assign pending_d = fft_valid ? 1'b1 : (load_work ? 1'b0 : pending_q);
   assign overrun_d = fft_valid & pending_q & ~load_work;

   // NOTE: the frame arrays are ordinary flops and are cleared with the rest of
   // the state, so a reset never leaves stale bins to be scanned later.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         pending_q <= 1'b0;
         k_q       <= '0;
         max_q     <= '0;
         idx_q     <= '0;
         freq_q    <= '0;
         done_q    <= 1'b0;
         overrun_q <= 1'b0;
         for (int i = 0; i < N_BINS; i++) begin
            cap_q[i]  <= '0;
            work_q[i] <= '0;
         end
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
         k_q       <= k_d;
         max_q     <= max_d;
         idx_q     <= idx_d;
         freq_q    <= freq_d;
         done_q    <= done_d;
         overrun_q <= overrun_d;
         for (int i = 0; i < N_BINS; i++) begin
            if (fft_valid) cap_q[i]  <= frame_in[i];
            if (load_work) work_q[i] <= cap_q[i];
         end
      end
   end

   assign done    = done_q;
   assign freq    = freq_q;
   assign overrun = overrun_q;
   assign busy    = pending_q | (state_q != IDLE) | done_q;

endmodule

// File: tb/tb_fas_peak_detect.sv
// Directed and randomized bench for fas_peak_detect; expected peaks come from
// a plain arithmetic argmax over the driven frame.
module tb_fas_peak_detect;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        fft_valid = 1'b0;
   logic [31:0] d [16];
   logic        done;
   logic [3:0]  freq;
   logic        busy;
   logic        overrun;

   int n_checks = 0;
   int n_pass   = 0;
   int done_cnt = 0;
   int ov_cnt   = 0;

   fas_peak_detect #(.W(16)) dut (
      .clk       (clk),
      .rst       (rst),
      .fft_valid (fft_valid),
      .fft_d0    (d[0]),
      .fft_d1    (d[1]),
      .fft_d2    (d[2]),
      .fft_d3    (d[3]),
      .fft_d4    (d[4]),
      .fft_d5    (d[5]),
      .fft_d6    (d[6]),
      .fft_d7    (d[7]),
      .fft_d8    (d[8]),
      .fft_d9    (d[9]),
      .fft_d10   (d[10]),
      .fft_d11   (d[11]),
      .fft_d12   (d[12]),
      .fft_d13   (d[13]),
      .fft_d14   (d[14]),
      .fft_d15   (d[15]),
      .done      (done),
      .freq      (freq),
      .busy      (busy),
      .overrun   (overrun)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (done === 1'b1)    done_cnt++;
      if (overrun === 1'b1) ov_cnt++;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      assert (obs === expv) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
   endtask

   // Index of the first bin with the largest re^2+im^2.
   function automatic logic [3:0] ref_peak();
      longint best = -1;
      logic [3:0] pk = '0;
      for (int k = 0; k < 16; k++) begin
         longint re = longint'($signed(d[k][31:16]));
         longint im = longint'($signed(d[k][15:0]));
         longint m  = re * re + im * im;
         if (m > best) begin
            best = m;
            pk   = 4'(k);
         end
      end
      return pk;
   endfunction

   task automatic clear_frame;
      for (int i = 0; i < 16; i++) d[i] = '0;
   endtask

   task automatic noise_frame(input int peak);
      for (int i = 0; i < 16; i++) begin
         logic [15:0] re = 16'($urandom_range(0, 200)) - 16'd100;
         logic [15:0] im = 16'($urandom_range(0, 200)) - 16'd100;
         d[i] = {re, im};
      end
      d[peak] = {16'd3000, 16'hF830};
   endtask

   task automatic send;
      fft_valid = 1'b1;
      tick();
      fft_valid = 1'b0;
   endtask

   task automatic wait_done(input string tag, input logic [3:0] exp_f, input int exp_lat);
      int lat  = 0;
      bit seen = 1'b0;
      for (int i = 1; i <= 60 && !seen; i++) begin
         tick();
         if (done === 1'b1) begin
            seen = 1'b1;
            lat  = i;
         end
      end
      chk({tag, "_seen"}, 32'(seen), 32'd1);
      if (seen) begin
         chk({tag, "_freq"}, 32'(freq), 32'(exp_f));
         if (exp_lat > 0) chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
         tick();
         chk({tag, "_pulse"}, 32'(done), 32'd0);
         chk({tag, "_hold"}, 32'(freq), 32'(exp_f));
      end
   endtask

   initial begin
      int ov0;
      int dc0;
      logic [3:0] expf;

      clear_frame();
      #2 rst = 1'b0;
      tick();
      tick();
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_freq", 32'(freq), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_ovr", 32'(overrun), 32'd0);
      rst = 1'b1;
      tick();

      // Single peak at bin 5.
      clear_frame();
      d[5] = {16'd100, 16'd0};
      send();
      chk("single_busy", 32'(busy), 32'd1);
      wait_done("single", 4'd5, 10);
      chk("single_idle", 32'(busy), 32'd0);
      chk("single_ovr", 32'(ov_cnt), 32'd0);

      // Ties keep the lower index.
      for (int i = 0; i < 16; i++) d[i] = {16'd3, 16'd4};
      d[3]  = {16'd0, 16'hFFD8};
      d[11] = {16'd0, 16'hFFD8};
      send();
      wait_done("tie_3_11", 4'd3, 10);
      for (int i = 0; i < 16; i++) d[i] = {16'd3, 16'd4};
      d[6] = {16'd0, 16'hFFD8};
      d[7] = {16'd0, 16'hFFD8};
      send();
      wait_done("tie_6_7", 4'd6, 10);

      // Extreme magnitudes must not wrap.
      clear_frame();
      d[15] = {16'h8000, 16'h8000};
      d[14] = {16'h7FFF, 16'h7FFF};
      send();
      wait_done("extreme", 4'd15, 10);

      // One frame every 16 cycles never overruns.
      ov0 = ov_cnt;
      noise_frame(1);  send(); wait_done("b2b_1", 4'd1, 10); repeat (4) tick();
      noise_frame(9);  send(); wait_done("b2b_9", 4'd9, 10); repeat (4) tick();
      noise_frame(0);  send(); wait_done("b2b_0", 4'd0, 10); repeat (4) tick();
      chk("b2b_no_ovr", 32'(ov_cnt - ov0), 32'd0);

      // New frame on the very edge the pending one is taken: no overrun.
      ov0 = ov_cnt;
      noise_frame(3);  send();
      noise_frame(10); send();
      wait_done("simul_a", 4'd3, 9);
      wait_done("simul_b", 4'd10, 9);
      chk("simul_no_ovr", 32'(ov_cnt - ov0), 32'd0);

      // Two frames during a scan: the first is overwritten and lost.
      ov0 = ov_cnt;
      noise_frame(2);  send();
      repeat (3) tick();
      noise_frame(4);  send();
      tick();
      noise_frame(12); send();
      wait_done("ovr_inflight", 4'd2, 0);
      wait_done("ovr_next", 4'd12, 0);
      chk("ovr_count", 32'(ov_cnt - ov0), 32'd1);

      // Reset in the middle of a scan.
      noise_frame(9);
      send();
      repeat (4) tick();
      @(posedge clk);
      #1 rst = 1'b0;
      #1;
      chk("mid_rst_done", 32'(done), 32'd0);
      chk("mid_rst_freq", 32'(freq), 32'd0);
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_ovr", 32'(overrun), 32'd0);
      tick();
      tick();
      rst = 1'b1;
      dc0 = done_cnt;
      repeat (15) tick();
      chk("mid_rst_no_done", 32'(done_cnt - dc0), 32'd0);
      noise_frame(7);
      send();
      wait_done("after_rst", 4'd7, 10);

      // All-zero frame reports bin 0 exactly once.
      clear_frame();
      dc0 = done_cnt;
      send();
      wait_done("zero", 4'd0, 10);
      repeat (10) tick();
      chk("zero_once", 32'(done_cnt - dc0), 32'd1);

      // Random full-range frames, then small-range frames rich in ties.
      for (int r = 0; r < 20; r++) begin
         for (int i = 0; i < 16; i++) d[i] = {16'($urandom), 16'($urandom)};
         expf = ref_peak();
         send();
         wait_done("rand_full", expf, 10);
         tick();
      end
      for (int r = 0; r < 20; r++) begin
         for (int i = 0; i < 16; i++)
            d[i] = {16'($urandom_range(0, 2)) - 16'd1, 16'($urandom_range(0, 2)) - 16'd1};
         expf = ref_peak();
         send();
         wait_done("rand_tie", expf, 10);
         tick();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/fas_peak_detect.md
# fas_peak_detect

Spectral peak detector that sits directly downstream of the FFT stage inside FAS. It captures one 16-bin complex spectrum per `fft_valid` pulse and computes the squared magnitude of every bin. It then reports the index of the strongest bin on `freq` together with a one-cycle `done` pulse. Bins are scanned two per cycle, so a result is always ready before the next 16-sample FFT frame arrives.

## Interface
- `W`, 16: width of the signed real and imaginary components of each bin.
- `clk` input 1: rising-edge clock.
- `rst` input 1: asynchronous, active-low reset.
- `fft_valid` input 1: one-cycle strobe; `fft_d0..fft_d15` hold a complete frame on this cycle.
- `fft_d0`..`fft_d15` input 32 each: bin k, with real part in [31:16] and imaginary part in [15:0], both two's complement.
- `done` output 1: one-cycle pulse; `freq` is valid on this cycle.
- `freq` output 4: index of the peak bin; holds its value until the next `done`.
- `busy` output 1: high while a frame is pending or being scanned.
- `overrun` output 1: one-cycle pulse when a new frame overwrites a pending, unscanned frame.

## Operation
- **Capture register.** On each `fft_valid`, all 16 bins are loaded into the capture register and `pending` is set.
  - If `pending` is already set, the old frame is overwritten and `overrun` is pulsed.
- **State machine.** States are IDLE, SCAN and REPORT.
  - IDLE, with `pending`=1: copy the capture register to the work register, clear `pending`, set `max`=0 and `idx`=0, then go to SCAN.
  - SCAN (counter k=0..7): evaluate bins 2k and 2k+1 against the running max.
    - A candidate replaces the max only if it is strictly greater. Ties therefore keep the lower index.
    - Within a pair, bin 2k is compared before bin 2k+1.
    - After k=7, go to REPORT.
  - REPORT: register `freq`=`idx`, pulse `done`, return to IDLE.
- **Simultaneous load and clear.** `fft_valid` in the same cycle that IDLE clears `pending` is legal.
  - The capture register takes the new frame and `pending` stays set.
  - The work copy comes from the register contents before that edge.
  - No `overrun` is raised.
- **Capture during a scan.** `fft_valid` during SCAN or REPORT is captured normally and does not disturb the scan in progress.
- **Arithmetic.** mag² = re² + im², with each square computed as a signed 16×16 product.
  - The largest square is (−32768)² = 2^30, so the sum is at most 2^31 and fits in a 32-bit unsigned value without saturation.
  - All comparisons are unsigned 32-bit.
- **All-zero frame.** `freq`=0.
- **Reset (`rst`=0, any time, including mid-scan).**
  - State goes to IDLE; `pending`, `k`, `max` and `idx` are cleared.
  - `done`=0, `freq`=0, `busy`=0, `overrun`=0.
  - Capture and work registers are cleared to 0.
  - A scan interrupted by reset produces no `done`.

## Timing
- Let edge T be the edge at which `fft_valid` is sampled.
- **Latency.**
  - IDLE loads at T+1.
  - SCAN runs on edges T+2..T+9.
  - `done` and the new `freq` appear after edge T+10, i.e. 10 cycles after the capture edge.
- **`busy`.** High from the cycle after T through the `done` cycle. It is also high during any cycle in which `pending`=1.
- **Throughput.** One frame per 10 cycles. A frame every 16 cycles never overruns.
- **Output registers.** `done`, `freq` and `overrun` are registered outputs with no combinational path from the inputs.

## Structure
- Shared package `fas_pkg` holds:
  - `N_BINS`=16 and `BIN_W`=32;
  - the state enum {IDLE, SCAN, REPORT};
  - the bin-unpack helper that returns the re/im fields.
- Sub-module `fas_mag2` is a combinational 16-bit re/im to 32-bit mag² unit. It is instantiated twice for the even and odd bins of each pair.

## Test plan
- **Single peak.** Bin 5 = (re 100, im 0), all other bins 0. Pulse `fft_valid` → `done` 10 cycles later, `freq`=5, `overrun`=0.
- **Tie.** Bins 3 and 11 both = (re 0, im −40), other bins = (3, 4). Expect `freq`=3 (lowest index wins); repeat with the tie on bins 6 and 7, expect `freq`=6.
- **Extreme values.** Bin 15 = (−32768, −32768), bin 14 = (32767, 32767). Expect `freq`=15; confirms the 32-bit sum does not wrap.
- **Back-to-back frames.** Frames every 16 cycles with peaks at bins 1, 9, 0 → three `done` pulses with `freq` = 1, 9, 0 in order, `overrun` never asserted. Then two `fft_valid` pulses 2 cycles apart during a scan, peaks at 4 and then 12:
  - `overrun` pulses once;
  - the in-flight scan's result is reported;
  - the next `done` reports `freq`=12, and peak 4 is never reported.
- **Reset mid-scan.** Assert `rst`=0 at edge T+5 of a scan. All outputs go to 0 immediately and no `done` follows. After release, a new frame with its peak at 7 yields `freq`=7 at normal latency.
- **All-zero frame.** Expect `freq`=0 and `done` pulsed exactly once.
